// File: rtl/chime_pkg.sv
// Shared types and constants for the doorbell chime controller:
// FSM state encoding, door and tone encodings, and the per-state
// output decode helpers used by the controller.
package chime_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TONE1 = 3'd1,
        GAP   = 3'd2,
        TONE2 = 3'd3,
        REST  = 3'd4
    } state_t;

    localparam logic DOOR_FRONT = 1'b0;
    localparam logic DOOR_BACK  = 1'b1;
    localparam logic TONE_A     = 1'b0;
    localparam logic TONE_B     = 1'b1;

    // Mux select for a given state and door: front plays a-then-b,
    // back plays b-then-a; GAP already presents the second tone.
    function automatic logic tone_sel(input state_t st, input logic door);
        logic s;
        case (st)
            TONE1:      s = (door == DOOR_BACK) ? TONE_B : TONE_A;
            GAP, TONE2: s = (door == DOOR_BACK) ? TONE_A : TONE_B;
            default:    s = TONE_A;
        endcase
        return s;
    endfunction

    // Tone gate: only the two tone states sound.
    function automatic logic tone_on(input state_t st);
        logic t;
        case (st)
            TONE1, TONE2: t = 1'b1;
            default:      t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/chime_timer.sv
// Load/decrement down-counter timing each chime phase. The owning FSM
// loads (duration-1) on state entry and leaves the state when done is
// high, i.e. when the count reads zero.
module chime_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/chime_controller.sv
// Doorbell chime sequencer and two-door arbiter.
// Captures rising edges of the front/back buttons into one pending flag
// per door, grants the chime to one door at a time and plays a two-tone
// pattern (TONE1, GAP, TONE2, REST) by driving sel and tone_en.
// Build option: define CHIME_FIXED_PRIORITY_EN to make front win every
// tie and drop the round-robin pointer; otherwise ties alternate.
module chime_controller
    import chime_pkg::*;
#(
    parameter int TONE_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_front,
    input  logic req_back,
    output logic sel,
    output logic tone_en,
    output logic grant_front,
    output logic grant_back,
    output logic busy,
    output logic door
);

    localparam int MAX_DUR = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_DUR + 1);
    localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_t        state_r;
    state_t        next_state_s;
    logic          req_front_q_r;
    logic          req_back_q_r;
    logic          pend_front_r;
    logic          pend_back_r;
    logic          rise_front_s;
    logic          rise_back_s;
    logic          grant_s;
    logic          grant_door_s;
    logic          door_next_s;
    logic          load_s;
    logic [CW-1:0] load_val_s;
    logic          done_s;
    logic          sel_r;
    logic          tone_en_r;
    logic          grant_front_r;
    logic          grant_back_r;
    logic          busy_r;
    logic          door_r;

    assign rise_front_s = req_front & ~req_front_q_r;
    assign rise_back_s  = req_back  & ~req_back_q_r;

    chime_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (load_val_s),
        .done     (done_s)
    );

    // Edge history and pending flags: a new edge sets the flag even in the
    // cycle its door is granted, so a re-press during its own chime queues a replay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_front_q_r <= 1'b0;
            req_back_q_r  <= 1'b0;
            pend_front_r  <= 1'b0;
            pend_back_r   <= 1'b0;
        end else begin
            req_front_q_r <= req_front;
            req_back_q_r  <= req_back;
            pend_front_r  <= rise_front_s |
                             (pend_front_r & ~(grant_s & (grant_door_s == DOOR_FRONT)));
            pend_back_r   <= rise_back_s |
                             (pend_back_r & ~(grant_s & (grant_door_s == DOOR_BACK)));
        end
    end

`ifdef CHIME_FIXED_PRIORITY_EN
    // Arbiter: front wins whenever it is pending.
    always_comb begin
        grant_door_s = DOOR_FRONT;
        if (pend_front_r) begin
            grant_door_s = DOOR_FRONT;
        end else if (pend_back_r) begin
            grant_door_s = DOOR_BACK;
        end else begin
            grant_door_s = DOOR_FRONT;
        end
    end
`else
    logic last_served_r;

    // Round-robin pointer: remembers the door granted most recently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_served_r <= DOOR_BACK;
        end else if (grant_s) begin
            last_served_r <= grant_door_s;
        end else begin
            last_served_r <= last_served_r;
        end
    end

    // Arbiter: a single pending door wins; a tie goes to the door not served last.
    always_comb begin
        grant_door_s = DOOR_FRONT;
        if (pend_front_r && pend_back_r) begin
            grant_door_s = ~last_served_r;
        end else if (pend_back_r) begin
            grant_door_s = DOOR_BACK;
        end else begin
            grant_door_s = DOOR_FRONT;
        end
    end
`endif

    // Next-state logic; each state entry loads the phase timer with duration-1.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = {CW{1'b0}};
        grant_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_front_r || pend_back_r) begin
                    next_state_s = TONE1;
                    load_s       = 1'b1;
                    load_val_s   = TONE_LOAD;
                    grant_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TONE1: begin
                if (done_s) begin
                    next_state_s = GAP;
                    load_s       = 1'b1;
                    load_val_s   = GAP_LOAD;
                end else begin
                    next_state_s = TONE1;
                end
            end
            GAP: begin
                if (done_s) begin
                    next_state_s = TONE2;
                    load_s       = 1'b1;
                    load_val_s   = TONE_LOAD;
                end else begin
                    next_state_s = GAP;
                end
            end
            TONE2: begin
                if (done_s) begin
                    next_state_s = REST;
                    load_s       = 1'b1;
                    load_val_s   = GAP_LOAD;
                end else begin
                    next_state_s = TONE2;
                end
            end
            REST: begin
                if (done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REST;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign door_next_s = grant_s ? grant_door_s : door_r;

    // State and output registers: outputs are decoded from the next state so
    // they line up with the state they describe on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            door_r        <= DOOR_FRONT;
            sel_r         <= TONE_A;
            tone_en_r     <= 1'b0;
            busy_r        <= 1'b0;
            grant_front_r <= 1'b0;
            grant_back_r  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            door_r        <= door_next_s;
            sel_r         <= tone_sel(next_state_s, door_next_s);
            tone_en_r     <= tone_on(next_state_s);
            busy_r        <= (next_state_s != IDLE);
            grant_front_r <= grant_s & (grant_door_s == DOOR_FRONT);
            grant_back_r  <= grant_s & (grant_door_s == DOOR_BACK);
        end
    end

    assign sel         = sel_r;
    assign tone_en     = tone_en_r;
    assign grant_front = grant_front_r;
    assign grant_back  = grant_back_r;
    assign busy        = busy_r;
    assign door        = door_r;

endmodule
